// File: rtl/barrel_projection_addr_gen_if.sv
// Bus bundle for the barrel-projection address generator: AXI-Stream pixel in/out
// plus the source-coordinate strobe toward the frame-memory reader.
interface barrel_projection_addr_gen_if;
    // A beat moves on a rising clock edge where tvalid && tready are both high;
    // a producer holds tdata/tuser stable while tvalid is high and tready is low.
    logic [15:0] AXIS_In_tdata;
    logic        AXIS_In_tvalid;
    logic        AXIS_In_tready;
    logic        AXIS_In_tuser;
    logic [15:0] AXIS_Out_tdata;
    logic        AXIS_Out_tvalid;
    logic        AXIS_Out_tready;
    logic        addr_vld;
    logic [11:0] xOut;
    logic [11:0] yOut;

    modport master (
        output AXIS_In_tdata, AXIS_In_tvalid, AXIS_In_tuser, AXIS_Out_tready,
        input  AXIS_In_tready, AXIS_Out_tdata, AXIS_Out_tvalid, addr_vld, xOut, yOut
    );

    modport slave (
        input  AXIS_In_tdata, AXIS_In_tvalid, AXIS_In_tuser, AXIS_Out_tready,
        output AXIS_In_tready, AXIS_Out_tdata, AXIS_Out_tvalid, addr_vld, xOut, yOut
    );
endinterface

// File: rtl/barrel_projection_addr_gen.sv
// Raster-scan barrel (cylindrical) source-address generator with a 3-stage
// arithmetic pipeline, plus an independent registered pixel FIFO.
module barrel_projection_addr_gen #(
    parameter int WIDTH      = 1080,
    parameter int HEIGHT     = 960,
    parameter int KCOEF      = 4096,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    barrel_projection_addr_gen_if.slave   bus
);

    localparam int                 AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        PTR_ONE  = 1;
    localparam logic [11:0]        X_MAX    = 12'(WIDTH);
    localparam logic [11:0]        Y_MAX    = 12'(HEIGHT);
    localparam logic signed [12:0] HALF_W   = 13'(WIDTH / 2);
    localparam logic signed [12:0] HALF_H   = 13'(HEIGHT / 2);
    localparam logic signed [30:0] HALF_H31 = 31'(HEIGHT / 2);
    localparam logic [15:0]        K16      = 16'(KCOEF);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    // ---------------- pixel FIFO ----------------
    logic [15:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_alive;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign bus.AXIS_In_tready  = r_alive && !w_full;
    assign bus.AXIS_Out_tvalid = !w_empty;
    assign bus.AXIS_Out_tdata  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = bus.AXIS_In_tvalid && bus.AXIS_In_tready;
    assign w_pop  = !w_empty && bus.AXIS_Out_tready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= bus.AXIS_In_tdata;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // ---------------- scan control ----------------
    state_t      r_state;
    logic [11:0] r_x;
    logic [11:0] r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.AXIS_In_tvalid) r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
            // Start-of-frame restarts the raster at the next issued position.
            if (w_push && bus.AXIS_In_tuser) begin
                r_x <= '0;
                r_y <= '0;
            end else if (r_state == ST_RUN) begin
                if (r_x == X_MAX) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_MAX) ? 12'd0 : r_y + 12'd1;
                end else begin
                    r_x <= r_x + 12'd1;
                end
            end
        end
    end

    // ---------------- arithmetic pipeline ----------------
    logic                r_v1, r_v2, r_v3;
    logic [11:0]         r_x1, r_x2, r_x3;
    logic [11:0]         r_y3;
    logic signed [12:0]  r_dx1, r_dy1, r_dy2;
    logic [16:0]         r_f2;

    logic [12:0]         w_adx;
    logic [19:0]         w_sq;
    logic [35:0]         w_prod;
    logic [19:0]         w_t;
    logic [20:0]         w_fdiff;
    logic [16:0]         w_f;
    logic signed [30:0]  w_p;
    logic signed [30:0]  w_yo;

    assign w_adx   = r_dx1[12] ? $unsigned(-r_dx1) : $unsigned(r_dx1);
    assign w_sq    = {7'b0, w_adx} * {7'b0, w_adx};
    assign w_prod  = {16'b0, w_sq} * {20'b0, K16};
    assign w_t     = 20'(w_prod >> 16);
    // Negative 1.0 - t shows up as bit 20 of the difference; clamp to zero.
    assign w_fdiff = 21'd65536 - {1'b0, w_t};
    assign w_f     = w_fdiff[20] ? 17'd0 : 17'(w_fdiff);
    assign w_p     = r_dy2 * $signed({1'b0, r_f2});
    assign w_yo    = HALF_H31 + (w_p >>> 16);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_x3  <= '0;
            r_y3  <= '0;
            r_dx1 <= '0;
            r_dy1 <= '0;
            r_dy2 <= '0;
            r_f2  <= '0;
        end else begin
            r_v1  <= (r_state == ST_RUN);
            r_x1  <= r_x;
            r_dx1 <= $signed({1'b0, r_x}) - HALF_W;
            r_dy1 <= $signed({1'b0, r_y}) - HALF_H;

            r_v2  <= r_v1;
            r_x2  <= r_x1;
            r_dy2 <= r_dy1;
            r_f2  <= w_f;

            r_v3  <= r_v2;
            r_x3  <= r_x2;
            r_y3  <= 12'(w_yo);
        end
    end

    assign bus.addr_vld = r_v3;
    assign bus.xOut     = r_x3;
    assign bus.yOut     = r_y3;

endmodule

// File: tb/tb_barrel_projection_addr_gen.sv
// Self-checking bench: raster/projection model, start-of-frame restart, a
// reduced-size frame wrap, and FIFO ordering under backpressure and random traffic.
module tb_barrel_projection_addr_gen;

    localparam int W  = 1080;
    localparam int H  = 960;
    localparam int K  = 4096;
    localparam int SW = 20;
    localparam int SH = 10;
    localparam int SK = 30000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] exp_q[$];
    logic [23:0] pipe_q[$];

    barrel_projection_addr_gen_if bus ();
    barrel_projection_addr_gen_if bus_s ();

    barrel_projection_addr_gen u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    barrel_projection_addr_gen #(
        .WIDTH(SW), .HEIGHT(SH), .KCOEF(SK), .FIFO_DEPTH(4)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ref_y(int x, int y, int wd, int ht, int kc);
        longint dx, sq, t, f, p, q;
        dx = longint'(x) - longint'(wd / 2);
        sq = dx * dx;
        t  = (sq * longint'(kc)) / 65536;
        f  = 65536 - t;
        if (f < 0) f = 0;
        p  = (longint'(y) - longint'(ht / 2)) * f;
        q  = p / 65536;
        if (p < 0 && q * 65536 != p) q = q - 1;
        return int'(longint'(ht / 2) + q);
    endfunction

    function automatic logic [23:0] next_pos(logic [23:0] pos, int wd, int ht);
        int x, y;
        x = int'(pos[23:12]);
        y = int'(pos[11:0]);
        if (x == wd) begin
            x = 0;
            y = (y == ht) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
        return {12'(x), 12'(y)};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_idle();
        bus.AXIS_In_tdata    = '0;
        bus.AXIS_In_tvalid   = 1'b0;
        bus.AXIS_In_tuser    = 1'b0;
        bus.AXIS_Out_tready  = 1'b0;
        bus_s.AXIS_In_tdata  = '0;
        bus_s.AXIS_In_tvalid = 1'b0;
        bus_s.AXIS_In_tuser  = 1'b0;
        bus_s.AXIS_Out_tready = 1'b0;
    endtask

    task automatic do_reset(int cycles);
        reset = 1'b0;
        drive_idle();
        repeat (cycles) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [41:0] obs;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.AXIS_In_tvalid  = 1'($urandom_range(0, 1));
            bus.AXIS_In_tuser   = 1'($urandom_range(0, 1));
            bus.AXIS_In_tdata   = 16'($urandom);
            bus.AXIS_Out_tready = 1'($urandom_range(0, 1));
            #1;
            obs = {bus.addr_vld, bus.xOut, bus.yOut, bus.AXIS_In_tready,
                   bus.AXIS_Out_tvalid, bus.AXIS_Out_tdata};
            tests_run++;
            if (obs !== 42'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %h, expected 0", i, obs);
            end
        end
    endtask

    task automatic test_startup_raster();
        logic [23:0] pos, e;
        logic [11:0] ex, ey;
        int pulses;
        pos = '0;
        pulses = 0;
        pipe_q.delete();
        bus.AXIS_In_tvalid  = 1'b1;
        bus.AXIS_In_tuser   = 1'b0;
        bus.AXIS_In_tdata   = 16'($urandom);
        bus.AXIS_Out_tready = 1'b1;
        reset = 1'b1;
        for (int n = 1; n <= 2300 && pulses < 2162; n++) begin
            @(negedge clk);
            pipe_q.push_back(pos);
            pos = next_pos(pos, W, H);
            tests_run++;
            if (pipe_q.size() == 4) begin
                e  = pipe_q.pop_front();
                ex = e[23:12];
                ey = 12'(ref_y(int'(e[23:12]), int'(e[11:0]), W, H, K));
                if (bus.addr_vld !== 1'b1 || bus.xOut !== ex || bus.yOut !== ey) begin
                    tests_failed++;
                    $display("FAIL raster pulse %0d: got vld=%0b x=%0d y=%0d, expected vld=1 x=%0d y=%0d",
                             pulses, bus.addr_vld, bus.xOut, bus.yOut, ex, ey);
                end
                pulses++;
                if (pulses == 1 || pulses == 541 || pulses == 2162) begin
                    ex = (pulses == 1) ? 12'd0   : (pulses == 541) ? 12'd540 : 12'd1080;
                    ey = (pulses == 1) ? 12'd133 : (pulses == 541) ? 12'd0   : 12'd134;
                    tests_run++;
                    if (bus.xOut !== ex || bus.yOut !== ey) begin
                        tests_failed++;
                        $display("FAIL raster_landmark pulse %0d: got x=%0d y=%0d, expected x=%0d y=%0d",
                                 pulses, bus.xOut, bus.yOut, ex, ey);
                    end
                end
            end else if (bus.addr_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL startup_latency cycle %0d: got addr_vld=%0b, expected 0", n, bus.addr_vld);
            end
        end
        tests_run++;
        if (pulses != 2162) begin
            tests_failed++;
            $display("FAIL raster_timeout: got %0d pulses, expected 2162", pulses);
        end
    endtask

    task automatic test_tuser();
        logic [23:0] pos, e;
        logic [11:0] ex, ey;
        int trig;
        do_reset(3);
        pos = '0;
        pipe_q.delete();
        trig = $urandom_range(30, 1200);
        bus.AXIS_In_tvalid  = 1'b1;
        bus.AXIS_Out_tready = 1'b1;
        reset = 1'b1;
        for (int n = 1; n <= trig + 12; n++) begin
            @(negedge clk);
            pipe_q.push_back(pos);
            if (pipe_q.size() == 4) begin
                e  = pipe_q.pop_front();
                ex = e[23:12];
                ey = 12'(ref_y(int'(e[23:12]), int'(e[11:0]), W, H, K));
                tests_run++;
                if (bus.addr_vld !== 1'b1 || bus.xOut !== ex || bus.yOut !== ey) begin
                    tests_failed++;
                    $display("FAIL tuser_stream cycle %0d: got vld=%0b x=%0d y=%0d, expected vld=1 x=%0d y=%0d",
                             n, bus.addr_vld, bus.xOut, bus.yOut, ex, ey);
                end
            end
            if (n == trig + 4) begin
                tests_run++;
                if (bus.xOut !== 12'd0 || bus.yOut !== 12'd133) begin
                    tests_failed++;
                    $display("FAIL tuser_restart: got x=%0d y=%0d, expected x=0 y=133", bus.xOut, bus.yOut);
                end
            end
            bus.AXIS_In_tdata = 16'($urandom);
            bus.AXIS_In_tuser = (n == trig);
            if (n == trig) begin
                tests_run++;
                if (bus.AXIS_In_tready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL tuser_ready: got tready=%0b, expected 1", bus.AXIS_In_tready);
                end
                pos = '0;
            end else begin
                pos = next_pos(pos, W, H);
            end
        end
        bus.AXIS_In_tuser = 1'b0;
    endtask

    task automatic test_small_frame();
        logic [23:0] pos, e;
        logic [11:0] ex, ey;
        do_reset(3);
        pos = '0;
        pipe_q.delete();
        bus_s.AXIS_In_tvalid  = 1'b1;
        bus_s.AXIS_Out_tready = 1'b1;
        reset = 1'b1;
        for (int n = 1; n <= 2 * (SW + 1) * (SH + 1) + 10; n++) begin
            @(negedge clk);
            pipe_q.push_back(pos);
            pos = next_pos(pos, SW, SH);
            bus_s.AXIS_In_tdata = 16'($urandom);
            tests_run++;
            if (pipe_q.size() == 4) begin
                e  = pipe_q.pop_front();
                ex = e[23:12];
                ey = 12'(ref_y(int'(e[23:12]), int'(e[11:0]), SW, SH, SK));
                if (bus_s.addr_vld !== 1'b1 || bus_s.xOut !== ex || bus_s.yOut !== ey) begin
                    tests_failed++;
                    $display("FAIL small_frame cycle %0d: got vld=%0b x=%0d y=%0d, expected vld=1 x=%0d y=%0d",
                             n, bus_s.addr_vld, bus_s.xOut, bus_s.yOut, ex, ey);
                end
            end else if (bus_s.addr_vld !== 1'b0) begin
                tests_failed++;
                $display("FAIL small_startup cycle %0d: got addr_vld=%0b, expected 0", n, bus_s.addr_vld);
            end
        end
        bus_s.AXIS_In_tvalid = 1'b0;
    endtask

    task automatic test_fifo_backpressure();
        int cnt;
        logic acc;
        logic [15:0] exp_d;
        do_reset(3);
        exp_q.delete();
        cnt = 0;
        acc = 1'b0;
        bus.AXIS_In_tvalid  = 1'b1;
        bus.AXIS_Out_tready = 1'b0;
        reset = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (acc) begin
                exp_q.push_back(16'(cnt));
                cnt++;
            end
            bus.AXIS_In_tdata = 16'(cnt);
            acc = bus.AXIS_In_tready;
            if (n >= 20) begin
                tests_run++;
                if (bus.addr_vld !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_addr_vld cycle %0d: got %0b, expected 1", n, bus.addr_vld);
                end
            end
        end
        tests_run++;
        if (cnt != 16 || bus.AXIS_In_tready !== 1'b0 || bus.AXIS_Out_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_fill: got accepted=%0d tready=%0b out_tvalid=%0b, expected 16 0 1",
                     cnt, bus.AXIS_In_tready, bus.AXIS_Out_tvalid);
        end
        bus.AXIS_In_tvalid  = 1'b0;
        bus.AXIS_Out_tready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
            exp_d = exp_q.pop_front();
            tests_run++;
            if (bus.AXIS_Out_tvalid !== 1'b1 || bus.AXIS_Out_tdata !== exp_d) begin
                tests_failed++;
                $display("FAIL bp_drain beat %0d: got tvalid=%0b data=%0d, expected tvalid=1 data=%0d",
                         n, bus.AXIS_Out_tvalid, bus.AXIS_Out_tdata, exp_d);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.AXIS_Out_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: got out_tvalid=%0b, expected 0", bus.AXIS_Out_tvalid);
        end
    endtask

    task automatic test_fifo_random();
        logic pend_in, pend_out;
        logic [15:0] pend_data;
        logic [41:0] obs;
        do_reset(3);
        exp_q.delete();
        pend_in  = 1'b0;
        pend_out = 1'b0;
        pend_data = '0;
        reset = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (pend_out) void'(exp_q.pop_front());
            if (pend_in) exp_q.push_back(pend_data);
            tests_run++;
            if (bus.AXIS_Out_tvalid !== (exp_q.size() != 0) ||
                bus.AXIS_In_tready !== (exp_q.size() < 16) ||
                (exp_q.size() != 0 && bus.AXIS_Out_tdata !== exp_q[0])) begin
                tests_failed++;
                $display("FAIL fifo_random cycle %0d: got tvalid=%0b tready=%0b data=%h, expected tvalid=%0b tready=%0b data=%h",
                         n, bus.AXIS_Out_tvalid, bus.AXIS_In_tready, bus.AXIS_Out_tdata,
                         exp_q.size() != 0, exp_q.size() < 16,
                         (exp_q.size() != 0) ? exp_q[0] : 16'h0);
            end
            bus.AXIS_In_tvalid  = ($urandom_range(0, 3) != 0);
            bus.AXIS_In_tdata   = 16'($urandom);
            bus.AXIS_Out_tready = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            pend_in   = bus.AXIS_In_tvalid && (exp_q.size() < 16);
            pend_out  = bus.AXIS_Out_tready && (exp_q.size() != 0);
            pend_data = bus.AXIS_In_tdata;
        end
        // Asynchronous abort between clock edges.
        bus.AXIS_In_tvalid = 1'b1;
        reset = 1'b0;
        #1;
        obs = {bus.addr_vld, bus.xOut, bus.yOut, bus.AXIS_In_tready,
               bus.AXIS_Out_tvalid, bus.AXIS_Out_tdata};
        tests_run++;
        if (obs !== 42'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h, expected 0", obs);
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_startup_raster();
        test_tuser();
        test_small_frame();
        test_fifo_backpressure();
        test_fifo_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
